// File: rtl/scroll_pkg.sv
// Shared types and constants for the scroll engine: FSM states, speed codes
// and the wrapping offset step used between frames.
package scroll_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SWEEP     = 2'd1,
    FRAME_END = 2'd2
  } state_t;

  localparam logic [1:0] SPD_PAUSE = 2'b00;
  localparam logic [1:0] SPD_SLOW  = 2'b01;
  localparam logic [1:0] SPD_MED   = 2'b10;
  localparam logic [1:0] SPD_FAST  = 2'b11;

  // One scroll step in [0, modulus-1], wrapping at both ends.
  function automatic int step_offset(input int off, input logic down, input int modulus);
    if (down) begin
      return (off == 32'sd0) ? modulus - 32'sd1 : off - 32'sd1;
    end else begin
      return (off == modulus - 32'sd1) ? 32'sd0 : off + 32'sd1;
    end
  endfunction

endpackage

// File: rtl/scroll_engine_if.sv
// Control inputs (speed switches) and pixel-sweep outputs of the scroll engine.
interface scroll_engine_if #(
  parameter int XW = 8,
  parameter int YW = 7
);
  logic          enable;
  logic [1:0]    speed_sel;
  logic          dir;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [YW-1:0] src_y;
  logic          plot;
  logic          frame_done;
  logic [YW-1:0] offset;

  modport master (
    input  enable, speed_sel, dir,
    output x, y, src_y, plot, frame_done, offset
  );

  modport slave (
    output enable, speed_sel, dir,
    input  x, y, src_y, plot, frame_done, offset
  );
endinterface

// File: rtl/scroll_tick_gen.sv
// Scroll-rate tick generator: one-cycle tick every DIV cycles of the selected
// speed; pause holds the counter at zero and any speed change restarts it.
module scroll_tick_gen
  import scroll_pkg::*;
#(
  parameter int DIV_SLOW = 25000000,
  parameter int DIV_MED  = 12500000,
  parameter int DIV_FAST = 6250000
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [1:0] speed_sel,
  output logic       tick
);
  localparam int DMAX = (DIV_SLOW > DIV_MED) ?
                        ((DIV_SLOW > DIV_FAST) ? DIV_SLOW : DIV_FAST) :
                        ((DIV_MED > DIV_FAST) ? DIV_MED : DIV_FAST);
  localparam int CW = (DMAX > 1) ? $clog2(DMAX) : 1;

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] term_s;
  logic [1:0]    sel_r;
  logic          changed_s;

  // Terminal count for the currently selected speed.
  always_comb begin
    term_s = '0;
    case (speed_sel)
      SPD_SLOW: term_s = CW'(DIV_SLOW - 1);
      SPD_MED:  term_s = CW'(DIV_MED - 1);
      SPD_FAST: term_s = CW'(DIV_FAST - 1);
      default:  term_s = '0;
    endcase
  end

  // A changed selection suppresses the tick in the very cycle it is seen.
  assign changed_s = (speed_sel != sel_r);
  assign tick      = !changed_s && (speed_sel != SPD_PAUSE) && (cnt_r == term_s);

  // Divider counter with clear on pause, speed change or terminal count.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_r <= '0;
      sel_r <= SPD_PAUSE;
    end else begin
      sel_r <= speed_sel;
      if (changed_s || (speed_sel == SPD_PAUSE) || (cnt_r == term_s)) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end
endmodule

// File: rtl/scroll_engine.sv
// Full-frame pixel sweep with a vertical scroll offset that only moves between
// frames; src_y addresses the background frame buffer row.
module scroll_engine
  import scroll_pkg::*;
#(
  parameter int XSCREEN  = 160,
  parameter int YSCREEN  = 120,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int DIV_SLOW = 25000000,
  parameter int DIV_MED  = 12500000,
  parameter int DIV_FAST = 6250000
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  scroll_engine_if.master  bus
);
  state_t        state_r;
  logic [XW-1:0] x_r;
  logic [YW-1:0] y_r;
  logic [YW-1:0] offset_r;
  logic [YW-1:0] next_offset_s;
  logic [YW-1:0] src_s;
  logic [YW:0]   sum_s;
  logic [YW:0]   wrap_s;
  logic          plot_r;
  logic          frame_done_r;
  logic          pending_r;
  logic          tick_s;

  scroll_tick_gen #(
    .DIV_SLOW (DIV_SLOW),
    .DIV_MED  (DIV_MED),
    .DIV_FAST (DIV_FAST)
  ) u_tick (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .speed_sel (bus.speed_sel),
    .tick      (tick_s)
  );

  assign next_offset_s = YW'(step_offset(int'(offset_r), bus.dir, YSCREEN));

  // Source row = (y + offset) wrapped once into [0, YSCREEN-1].
  always_comb begin
    sum_s  = {1'b0, y_r} + {1'b0, offset_r};
    wrap_s = sum_s - (YW+1)'(YSCREEN);
    if (sum_s >= (YW+1)'(YSCREEN)) begin
      src_s = wrap_s[YW-1:0];
    end else begin
      src_s = sum_s[YW-1:0];
    end
  end

  // Sweep FSM: pixel counters, pending scroll request and frame-boundary offset update.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_r      <= IDLE;
      x_r          <= '0;
      y_r          <= '0;
      plot_r       <= 1'b0;
      frame_done_r <= 1'b0;
      pending_r    <= 1'b0;
      offset_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          x_r          <= '0;
          y_r          <= '0;
          frame_done_r <= 1'b0;
          pending_r    <= pending_r | tick_s;
          if (bus.enable) begin
            state_r <= SWEEP;
            plot_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            plot_r  <= 1'b0;
          end
        end
        SWEEP: begin
          pending_r    <= pending_r | tick_s;
          frame_done_r <= 1'b0;
          if (x_r == XW'(XSCREEN - 1)) begin
            x_r <= '0;
            if (y_r == YW'(YSCREEN - 1)) begin
              y_r          <= '0;
              state_r      <= FRAME_END;
              plot_r       <= 1'b0;
              frame_done_r <= 1'b1;
            end else begin
              y_r    <= y_r + YW'(1);
              plot_r <= 1'b1;
            end
          end else begin
            x_r    <= x_r + XW'(1);
            plot_r <= 1'b1;
          end
        end
        FRAME_END: begin
          x_r          <= '0;
          y_r          <= '0;
          frame_done_r <= 1'b0;
          pending_r    <= 1'b0;
          if (pending_r || tick_s) begin
            offset_r <= next_offset_s;
          end else begin
            offset_r <= offset_r;
          end
          if (bus.enable) begin
            state_r <= SWEEP;
            plot_r  <= 1'b1;
          end else begin
            state_r <= IDLE;
            plot_r  <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          x_r          <= '0;
          y_r          <= '0;
          plot_r       <= 1'b0;
          frame_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x          = x_r;
  assign bus.y          = y_r;
  assign bus.src_y      = src_s;
  assign bus.plot       = plot_r;
  assign bus.frame_done = frame_done_r;
  assign bus.offset     = offset_r;
endmodule

// File: tb/tb_scroll_engine.sv
// Self-checking bench for scroll_engine on a 4x3 screen with short dividers.
// A frame-position/tick-count model predicts every output each cycle.
module tb_scroll_engine;
  localparam int XS = 4;
  localparam int YS = 3;
  localparam int XW = 2;
  localparam int YW = 2;
  localparam int DS = 5;
  localparam int DM = 3;
  localparam int DF = 2;
  localparam int N  = XS * YS;

  logic CLOCK_50 = 1'b0;
  logic resetn   = 1'b0;
  int   errors   = 0;
  int   checks   = 0;

  // Model: -1 idle, 0..N-1 pixel index within the frame, N frame end.
  int m_pos  = -1;
  int m_off  = 0;
  int m_pend = 0;
  int m_prev = 0;
  int m_run  = 0;

  scroll_engine_if #(.XW(XW), .YW(YW)) bus ();

  scroll_engine #(
    .XSCREEN(XS), .YSCREEN(YS), .XW(XW), .YW(YW),
    .DIV_SLOW(DS), .DIV_MED(DM), .DIV_FAST(DF)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .bus      (bus)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model advanced on every active edge.
  initial forever begin : model
    int spd;
    int dv;
    int tk;
    @(posedge CLOCK_50 or negedge resetn);
    if (!resetn) begin
      m_pos = -1; m_off = 0; m_pend = 0; m_prev = 0; m_run = 0;
    end else begin
      spd = int'(bus.speed_sel);
      tk  = 0;
      if (spd != m_prev || spd == 0) begin
        m_run = 0;
      end else begin
        m_run++;
        dv = (spd == 1) ? DS : ((spd == 2) ? DM : DF);
        tk = ((m_run % dv) == 0) ? 1 : 0;
      end
      m_prev = spd;
      if (m_pos == N) begin
        if (m_pend != 0 || tk != 0)
          m_off = bus.dir ? (m_off + YS - 1) % YS : (m_off + 1) % YS;
        m_pend = 0;
      end else begin
        m_pend = (m_pend != 0 || tk != 0) ? 1 : 0;
      end
      if (m_pos == -1 || m_pos == N) m_pos = bus.enable ? 0 : -1;
      else m_pos = m_pos + 1;
    end
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin : compare
    int ep;
    int ex;
    int ey;
    @(negedge CLOCK_50);
    ep = (m_pos >= 0 && m_pos < N) ? 1 : 0;
    ex = (ep != 0) ? m_pos % XS : 0;
    ey = (ep != 0) ? m_pos / XS : 0;
    chk("plot", int'(bus.plot), ep);
    chk("x", int'(bus.x), ex);
    chk("y", int'(bus.y), ey);
    chk("frame_done", int'(bus.frame_done), (m_pos == N) ? 1 : 0);
    chk("offset", int'(bus.offset), m_off);
    chk("src_y", int'(bus.src_y), (ey + m_off) % YS);
  end

  task automatic wait_xy(input int tx, input int ty);
    bit found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge CLOCK_50);
      if (bus.plot && int'(bus.x) == tx && int'(bus.y) == ty) found = 1'b1;
    end
    chk("reach_xy", int'(found), 1);
  endtask

  task automatic wait_fd(output int n, output int pc);
    bit found = 1'b0;
    n = 0; pc = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge CLOCK_50);
      n++;
      if (bus.plot) pc++;
      if (bus.frame_done) found = 1'b1;
    end
    chk("frame_done_seen", int'(found), 1);
  endtask

  initial begin : main
    int n;
    int pc;
    int saved;
    bus.enable = 1'b0; bus.speed_sel = 2'b00; bus.dir = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    chk("rst_x", int'(bus.x), 0);
    chk("rst_plot", int'(bus.plot), 0);
    chk("rst_offset", int'(bus.offset), 0);
    chk("rst_src_y", int'(bus.src_y), 0);

    // Paused sweep: 12 plots, frame_done on the 13th cycle.
    bus.enable = 1'b1;
    wait_fd(n, pc);
    chk("pause_fd_cycle", n, 13);
    chk("pause_plots", pc, 12);
    chk("pause_offset", int'(bus.offset), 0);

    // Slow forward scroll: 1, 2, 0.
    bus.speed_sel = 2'b01; bus.dir = 1'b0;
    wait_fd(n, pc); @(negedge CLOCK_50); chk("slow_off1", int'(bus.offset), 1);
    wait_fd(n, pc); @(negedge CLOCK_50); chk("slow_off2", int'(bus.offset), 2);
    wait_xy(0, 2); chk("slow_src_y2", int'(bus.src_y), 1);
    wait_fd(n, pc); @(negedge CLOCK_50); chk("slow_off0", int'(bus.offset), 0);

    // Fast reverse scroll: 2 then 1.
    bus.dir = 1'b1; bus.speed_sel = 2'b11;
    wait_fd(n, pc); @(negedge CLOCK_50);
    chk("rev_off2", int'(bus.offset), 2);
    chk("rev_src_y0", int'(bus.src_y), 2);
    wait_fd(n, pc); @(negedge CLOCK_50); chk("rev_off1", int'(bus.offset), 1);

    // Coincident tick on the frame-end cycle.
    bus.speed_sel = 2'b00;
    wait_fd(n, pc); wait_fd(n, pc);
    @(negedge CLOCK_50); chk("pause_hold", int'(bus.offset), 1);
    wait_xy(3, 1);
    bus.speed_sel = 2'b01; bus.dir = 1'b0;
    wait_fd(n, pc); chk("coinc_fd_delay", n, 5);
    @(negedge CLOCK_50);
    bus.speed_sel = 2'b00;
    chk("coinc_step", int'(bus.offset), 2);
    wait_fd(n, pc); @(negedge CLOCK_50); chk("coinc_no_carry", int'(bus.offset), 2);

    // Asynchronous reset mid-frame.
    wait_xy(2, 1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_x", int'(bus.x), 0);
    chk("arst_y", int'(bus.y), 0);
    chk("arst_plot", int'(bus.plot), 0);
    chk("arst_offset", int'(bus.offset), 0);
    chk("arst_fd", int'(bus.frame_done), 0);
    @(negedge CLOCK_50); resetn = 1'b1;
    @(negedge CLOCK_50);
    chk("restart_plot", int'(bus.plot), 1);
    chk("restart_x", int'(bus.x), 0);

    // Enable drop: frame completes, then idle.
    wait_xy(1, 0);
    bus.enable = 1'b0;
    wait_fd(n, pc);
    chk("drop_fd_delay", n, 11);
    chk("drop_plots", pc, 10);
    repeat (3) begin
      @(negedge CLOCK_50);
      chk("drop_idle_plot", int'(bus.plot), 0);
    end

    // Speed changing every cycle never ticks.
    bus.enable = 1'b1;
    saved = m_off;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLOCK_50);
      bus.speed_sel = (i % 2 == 0) ? 2'b01 : 2'b10;
    end
    chk("toggle_no_step", int'(bus.offset), saved);
    bus.speed_sel = 2'b00;

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      @(negedge CLOCK_50);
      if ($urandom_range(0, 15) == 0) bus.speed_sel = 2'($urandom_range(0, 3));
      bus.enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 7) == 0) bus.dir = ~bus.dir;
      if (!resetn) begin
        #2 resetn = 1'b1;
      end else if ($urandom_range(0, 499) == 0) begin
        #2 resetn = 1'b0;
      end
    end
    if (!resetn) begin
      @(negedge CLOCK_50);
      #2 resetn = 1'b1;
    end
    repeat (2) @(negedge CLOCK_50);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/scroll_engine.md
Name: scroll_engine

Overview:
- Parametrised successor to the single-speed background scroller.
- Owns the full-frame pixel sweep (x, y, plot) plus a vertical scroll offset; outputs the wrapped source row (src_y) that addresses the background frame buffer.
- Adds selectable speed, direction reversal, pause, and tear-free offset update: the offset changes only between frames.
- Sits between the speed switches and vga_adapter, driving its x/y/plot inputs.

Parameters:
- XSCREEN, 160, pixels per row.
- YSCREEN, 120, rows per frame; also the offset modulus.
- XW, 8, x width; 2**XW >= XSCREEN.
- YW, 7, y, src_y and offset width; 2**YW >= YSCREEN.
- DIV_SLOW, 25000000, CLOCK_50 cycles per tick at speed 01 (0.5 s).
- DIV_MED, 12500000, cycles per tick at speed 10 (0.25 s).
- DIV_FAST, 6250000, cycles per tick at speed 11 (0.125 s).

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- enable  in  1  run frame sweeps while high.
- speed_sel  in  2  00 pause, 01 slow, 10 med, 11 fast.
- dir  in  1  0 = offset increments, 1 = offset decrements.
- x  out  XW  pixel column.
- y  out  YW  screen row.
- src_y  out  YW  background row = (y + offset) mod YSCREEN.
- plot  out  1  x/y/src_y valid this cycle.
- frame_done  out  1  one-cycle pulse at end of frame.
- offset  out  YW  current scroll offset.

Behaviour:
- Reset (async, resetn=0): x=0, y=0, offset=0, plot=0, frame_done=0, state=IDLE, tick counter=0, pending=0. src_y is therefore 0.
- State IDLE: plot=0, x=y=0. Goes to SWEEP on the next edge when enable=1.
- State SWEEP: plot=1 every cycle, all outputs registered.
  - x increments each cycle.
  - At x=XSCREEN-1: x goes to 0 and y increments.
  - At x=XSCREEN-1 and y=YSCREEN-1: go to FRAME_END.
  - One frame = XSCREEN*YSCREEN plot cycles, no gaps.
- State FRAME_END (one cycle): plot=0, frame_done=1, x=y=0.
  - Offset step is applied if (pending | tick).
  - Next state is SWEEP if enable=1, else IDLE.
- enable deasserted mid-frame: the current frame completes through FRAME_END, then IDLE. The frame is never truncated.
- Tick generator:
  - Counts 0..DIV-1 for the selected speed; tick=1 for one cycle at terminal count.
  - speed_sel=00: counter held at 0, no ticks.
  - Any change of speed_sel clears the counter in the same cycle; no tick that cycle.
- pending flag: pending_next = (tick & ~in_FRAME_END) | (pending & ~in_FRAME_END).
  - Multiple ticks within one frame collapse to a single step, so the offset changes by at most 1 per frame.
  - A tick coincident with FRAME_END is applied immediately and not carried.
- Offset step:
  - dir=0: offset = (offset==YSCREEN-1) ? 0 : offset+1.
  - dir=1: offset = (offset==0) ? YSCREEN-1 : offset-1.
  - dir is sampled only in FRAME_END.
- src_y: combinational from registered y and offset as s = y + offset (YW+1 bits); src_y = (s >= YSCREEN) ? s-YSCREEN : s. No % operator. Offset stays within [0, YSCREEN-1] at all times.
- Reset mid-frame: all outputs clear asynchronously; after release the block restarts from IDLE.

Decomposition:
- Package scroll_pkg:
  - state enum {IDLE, SWEEP, FRAME_END}.
  - speed codes SPD_PAUSE=2'b00, SPD_SLOW=2'b01, SPD_MED=2'b10, SPD_FAST=2'b11.
- Sub-module scroll_tick_gen:
  - Parameters DIV_SLOW/MED/FAST; ports CLOCK_50, resetn, speed_sel, tick.
  - Owns the counter and the speed-change clear.
- Top level holds the FSM, x/y counters, pending flag, offset, and src_y wrap logic.

Test Plan (XSCREEN=4, YSCREEN=3, DIV_SLOW=5, DIV_MED=3, DIV_FAST=2):
- Pause sweep: reset, enable=1, speed 00 -> 12 plot cycles, x 0..3 per row, y 0..2. frame_done at cycle 13 after leaving IDLE; offset stays 0; src_y==y throughout.
- Slow scroll with wrap: speed 01, dir 0 -> ~2 ticks per 13-cycle frame collapse. Offset goes 1, 2, 0 at successive frame_done pulses. With offset=2, y=2 gives src_y=1.
- Reverse wrap: from offset 0, dir=1, speed 11 -> offset=2 after first FRAME_END, then 1. y=0 gives src_y=2.
- Coincident tick: align a tick with FRAME_END (pending=0 before) -> offset changes by exactly 1; pending=0 in the next cycle; no extra step at the following frame if no new tick.
- Async reset mid-frame: assert resetn=0 at x=2, y=1 between clock edges -> x, y, plot, offset and frame_done go to 0 before the next edge; after release with enable=1, sweep restarts at x=0, y=0.
- Enable drop / speed change: enable=0 at x=1, y=0 -> sweep continues to x=3, y=2, then frame_done and IDLE with plot=0. Changing speed_sel mid-count -> tick counter reads 0 on the next cycle and no tick is issued.
